mac_layer: RTL and testbench

Parametrised multiply-accumulate layer engine: LANES neurons compute in parallel from one broadcast input stream, each with its own weight and bias. Operands are DATA_W-bit sign-magnitude values. The block adds a saturating accumulator, per-layer term count, input/output valid-ready handshakes and output scaling. It sits between the weight/input memories and the activation write-back of the network datapath.

---
 rtl/mac_layer.sv | 143 ++++++++++++++
 tb/tb_mac_layer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mac_layer.sv
// mac_layer: LANES parallel sign-magnitude multiply-accumulate neurons with saturating
// accumulators and valid/ready handshakes. Define MAC_RELU_EN to clamp negative results to +0.
module mac_layer #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int LEN_W     = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          num_terms,
  input  logic [LANES*DATA_W-1:0]   cur_bios,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         cur_input,
  input  logic [LANES*DATA_W-1:0]   cur_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   result,
  output logic                      busy
);
  localparam int MAG_W = DATA_W - 1;
  localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**MAG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_HOLD} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] terms_reg, cnt_reg;
  logic             load, beat, last_beat, round_en;

  // Negative zero maps onto plain zero in two's complement.
  function automatic logic signed [DATA_W-1:0] sm_to_tc(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] mag;
    mag = $signed({1'b0, v[MAG_W-1:0]});
    return v[DATA_W-1] ? -mag : mag;
  endfunction

  assign load      = (state_reg == S_IDLE) && start;
  assign beat      = in_valid && in_ready;
  assign last_beat = (cnt_reg + LEN_W'(1)) == terms_reg;
  assign round_en  = (state_reg == S_ROUND);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (num_terms == '0) ? S_ROUND : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_next = S_ROUND;
      end
      S_ROUND: state_next = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      terms_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        terms_reg <= num_terms;
        cnt_reg   <= '0;
      end else if (beat) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
    end
  end

  logic signed [DATA_W-1:0] in_tc;
  assign in_tc = sm_to_tc(cur_input);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0]   w_tc, b_tc;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    acc_reg, acc_next, acc_shift;
      logic signed [ACC_W:0]      acc_sum, rnd_sum, rnd_abs;
      logic [DATA_W-1:0]          bias_reg, res_reg, res_next;
      logic [MAG_W-1:0]           rnd_mag;
      logic                       rnd_neg;

      assign w_tc      = sm_to_tc(cur_weight[gi*DATA_W +: DATA_W]);
      assign b_tc      = sm_to_tc(bias_reg);
      assign prod      = in_tc * w_tc;
      assign acc_sum   = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(prod);
      assign acc_shift = acc_reg >>> OUT_SHIFT;
      assign rnd_sum   = (ACC_W+1)'(acc_shift) + (ACC_W+1)'(b_tc);

      // Clamp symmetrically so the accumulator never wraps and stays movable.
      always_comb begin
        acc_next = acc_sum[ACC_W-1:0];
        if (acc_sum > ACC_MAX)      acc_next = ACC_MAX[ACC_W-1:0];
        else if (acc_sum < ACC_MIN) acc_next = ACC_MIN[ACC_W-1:0];
      end

      always_comb begin
        rnd_neg  = rnd_sum[ACC_W];
        rnd_abs  = rnd_neg ? -rnd_sum : rnd_sum;
        rnd_mag  = (rnd_abs > OUT_MAX) ? {MAG_W{1'b1}} : rnd_abs[MAG_W-1:0];
        res_next = {rnd_neg, rnd_mag};
`ifdef MAC_RELU_EN
        if (rnd_neg) res_next = '0;
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg  <= '0;
          bias_reg <= '0;
          res_reg  <= '0;
        end else begin
          if (load) begin
            acc_reg  <= '0;
            bias_reg <= cur_bios[gi*DATA_W +: DATA_W];
          end else if (beat) begin
            acc_reg <= acc_next;
          end
          if (round_en) res_reg <= res_next;
        end
      end

      assign result[gi*DATA_W +: DATA_W] = res_reg;
    end
  endgenerate
endmodule

// File: tb/tb_mac_layer.sv
// Directed self-checking bench for mac_layer; expected values are hand-computed.
module tb_mac_layer;
`ifdef MAC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [5:0]  num_terms;
  logic [31:0] cur_bios, cur_weight;
  logic [7:0]  cur_input;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  int          n_checks = 0;
  int          n_errors = 0;

  mac_layer dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .cur_bios(cur_bios),
    .in_valid(in_valid), .in_ready(in_ready), .cur_input(cur_input),
    .cur_weight(cur_weight), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [5:0] n, input logic [31:0] bias);
    start = 1'b1; num_terms = n; cur_bios = bias;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] x, input logic [31:0] w);
    in_valid = 1'b1; cur_input = x; cur_weight = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_hold(input string tag);
    $display("%s: result=%h", tag, result);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num_terms = '0; cur_bios = '0; cur_weight = '0; cur_input = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);

    // Lane 0: 3*3 + 3*(-6) + 2*(-8) + 5 = -20; in_valid offered in IDLE is ignored
    in_valid = 1'b1; cur_input = 8'h7F; cur_weight = 32'h7F7F7F7F;
    do_start(6'd3, 32'h0000_0005);
    in_valid = 1'b0;
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    beat(8'h03, 32'h0000_0003);
    tick();
    chk("t1_gap_in_ready", {31'd0, in_ready}, 32'd1);
    beat(8'h03, 32'h0000_0086);
    beat(8'h02, 32'h0000_0088);
    chk("t1_round_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_round_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_result", result, RELU ? 32'h0000_0000 : 32'h0000_0094);
    release_hold("t1");
    chk("t1_result_kept", result, RELU ? 32'h0000_0000 : 32'h0000_0094);

    // Zero-bubble start; 4 beats of +-127*127 saturate every lane
    do_start(6'd4, 32'h0);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) beat(8'h7F, 32'hFFFF_7F7F);
    tick();
    chk("t2_result", result, RELU ? 32'h0000_7F7F : 32'hFFFF_7F7F);
    release_hold("t2");

    // Saturate, then pull back: lane0 ends at +1, lane1 at -1
    do_start(6'd6, 32'h0);
    for (int i = 0; i < 3; i++) beat(8'h7F, 32'hFF7F_FF7F);
    for (int i = 0; i < 2; i++) beat(8'h7F, 32'hFF7F_7FFF);
    beat(8'h7F, 32'hFF7F_0484);
    tick();
    chk("t3_result", result, RELU ? 32'h007F_0001 : 32'hFF7F_8101);
    release_hold("t3");

    // Input -0: lane0 bias -3, lane1 bias -0, lane2 weight -5, lane3 bias +3
    do_start(6'd2, 32'h0300_8083);
    for (int i = 0; i < 2; i++) beat(8'h80, 32'h0585_0505);
    tick();
    chk("t4_result", result, RELU ? 32'h0300_0000 : 32'h0300_0083);
    release_hold("t4");

    // num_terms 0: bias straight through, no in_ready, then a stalled HOLD
    do_start(6'd0, 32'h0182_7F00);
    chk("t5_no_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_round_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t5_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_result", result, RELU ? 32'h0100_7F00 : 32'h0182_7F00);
    start = 1'b1; num_terms = 6'd3; in_valid = 1'b1; cur_input = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t5_hold_result", result, RELU ? 32'h0100_7F00 : 32'h0182_7F00);
    end
    start = 1'b0; in_valid = 1'b0;
    release_hold("t5");

    // Reset after 2 of 4 beats, then a fresh single-beat layer
    do_start(6'd4, 32'h0);
    beat(8'h01, 32'h0101_0101);
    beat(8'h01, 32'h0101_0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_result", result, 32'd0);
    tick();
    chk("t6_no_out_valid", {31'd0, out_valid}, 32'd0);
    do_start(6'd1, 32'h0);
    beat(8'h02, 32'h0303_0303);
    tick();
    chk("t6_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_result", result, 32'h0606_0606);
    release_hold("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
